// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and the
// per-stage register control pair.
package pipe_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StIWait = 2'd1,
    StDWait = 2'd2
  } state_e;

  // Bit order {we, zero}: zero loads a bubble only when we is also set.
  typedef struct packed {
    logic we;
    logic zero;
  } stage_ctrl_t;

  localparam stage_ctrl_t StageAdvance = '{we: 1'b1, zero: 1'b0};
  localparam stage_ctrl_t StageBubble  = '{we: 1'b1, zero: 1'b1};
  localparam stage_ctrl_t StageHold    = '{we: 1'b0, zero: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  output logic              load_use_o
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs_i) || (id_use_rt_i && (ex_rd_i == id_rt_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: stage register controls, PC write and
// redirect, pending-redirect tracking across I-cache misses, and a stall cycle counter.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_br_taken_i,
  input  logic [XLEN-1:0]   ex_br_target_i,
  input  logic              i_req_i,
  input  logic              i_ready_i,
  input  logic              d_req_i,
  input  logic              d_ready_i,
  output logic              pc_we_o,
  output logic              pc_redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              if_id_we_o,
  output logic              if_id_zero_o,
  output logic              id_ex_we_o,
  output logic              id_ex_zero_o,
  output logic              ex_mem_we_o,
  output logic              ex_mem_zero_o,
  output logic              mem_wb_we_o,
  output logic              mem_wb_zero_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              load_use;
  logic              dmiss;
  logic              imiss;
  logic              pc_we;
  logic              pc_redirect;
  stage_ctrl_t       if_id, id_ex, ex_mem, mem_wb;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .id_rs_i       (id_rs_i),
    .id_rt_i       (id_rt_i),
    .id_use_rt_i   (id_use_rt_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_mem_read_i),
    .load_use_o    (load_use)
  );

  assign dmiss = d_req_i && !d_ready_i;
  // Once waiting, the fetch stays outstanding until the cache returns data.
  assign imiss = (state_q == StIWait) ? !i_ready_i : (i_req_i && !i_ready_i);

  always_comb begin
    state_d       = StRun;
    pend_d        = pend_q;
    redirect_pc_d = redirect_pc_q;
    pc_we         = 1'b1;
    pc_redirect   = 1'b0;
    if_id         = StageAdvance;
    id_ex         = StageAdvance;
    ex_mem        = StageAdvance;
    mem_wb        = StageAdvance;

    if (dmiss) begin
      // Freeze everything up to MEM; the branch in EX is re-presented after the miss.
      pc_we   = 1'b0;
      if_id   = StageHold;
      id_ex   = StageHold;
      ex_mem  = StageHold;
      mem_wb  = StageBubble;
      state_d = StDWait;
    end else if (ex_br_taken_i) begin
      if_id         = StageBubble;
      id_ex         = StageBubble;
      redirect_pc_d = ex_br_target_i;
      if (imiss) begin
        pc_we   = 1'b0;
        pend_d  = 1'b1;
        state_d = StIWait;
      end else begin
        pc_redirect = 1'b1;
        pend_d      = 1'b0;
      end
    end else if (imiss) begin
      pc_we   = 1'b0;
      if_id   = StageBubble;
      state_d = StIWait;
    end else if (state_q == StIWait) begin
      // Fetch returned; a pending redirect makes the returned instruction stale.
      if (pend_q) begin
        if_id       = StageBubble;
        pc_redirect = 1'b1;
        pend_d      = 1'b0;
      end
    end else if (load_use) begin
      pc_we = 1'b0;
      if_id = StageHold;
      id_ex = StageBubble;
    end

    stall_cnt_d = pc_we ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StRun;
      pend_q        <= 1'b0;
      redirect_pc_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      redirect_pc_q <= redirect_pc_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pc_we_o        = pc_we;
  assign pc_redirect_o  = pc_redirect;
  assign redirect_pc_o  = redirect_pc_q;
  assign if_id_we_o     = if_id.we;
  assign if_id_zero_o   = if_id.zero;
  assign id_ex_we_o     = id_ex.we;
  assign id_ex_zero_o   = id_ex.zero;
  assign ex_mem_we_o    = ex_mem.we;
  assign ex_mem_zero_o  = ex_mem.zero;
  assign mem_wb_we_o    = mem_wb.we;
  assign mem_wb_zero_o  = mem_wb.zero;
  assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl; uses a narrow stall counter so the
// wrap-around is reachable.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 4;

  // Expected control word: {pc_we, pc_redirect, if_id we/zero, id_ex, ex_mem, mem_wb}
  localparam logic [9:0] Norm    = 10'b10_10_10_10_10;
  localparam logic [9:0] LdUse   = 10'b00_00_11_10_10;
  localparam logic [9:0] Br      = 10'b11_11_11_10_10;
  localparam logic [9:0] BrPend  = 10'b00_11_11_10_10;
  localparam logic [9:0] IMiss   = 10'b00_11_10_10_10;
  localparam logic [9:0] IRdyPnd = 10'b11_11_10_10_10;
  localparam logic [9:0] DMiss   = 10'b00_00_00_00_11;

  typedef struct {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rt;
    logic [4:0]  rd;
    logic        mem_read;
    logic        br;
    logic [31:0] tgt;
    logic        i_req;
    logic        i_ready;
    logic        d_req;
    logic        d_ready;
    logic [9:0]  ctl;
    logic [31:0] rpc;
    logic [31:0] cnt;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      id_rs, id_rt, ex_rd;
  logic            id_use_rt, ex_mem_read, ex_br_taken;
  logic [31:0]     ex_br_target;
  logic            i_req, i_ready, d_req, d_ready;
  logic            pc_we, pc_redirect;
  logic [31:0]     redirect_pc;
  logic            if_id_we, if_id_zero, id_ex_we, id_ex_zero;
  logic            ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero;
  logic [CntW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .XLEN   (32),
    .REG_AW (5),
    .CNT_W  (CntW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_use_rt_i    (id_use_rt),
    .ex_rd_i        (ex_rd),
    .ex_mem_read_i  (ex_mem_read),
    .ex_br_taken_i  (ex_br_taken),
    .ex_br_target_i (ex_br_target),
    .i_req_i        (i_req),
    .i_ready_i      (i_ready),
    .d_req_i        (d_req),
    .d_ready_i      (d_ready),
    .pc_we_o        (pc_we),
    .pc_redirect_o  (pc_redirect),
    .redirect_pc_o  (redirect_pc),
    .if_id_we_o     (if_id_we),
    .if_id_zero_o   (if_id_zero),
    .id_ex_we_o     (id_ex_we),
    .id_ex_zero_o   (id_ex_zero),
    .ex_mem_we_o    (ex_mem_we),
    .ex_mem_zero_o  (ex_mem_zero),
    .mem_wb_we_o    (mem_wb_we),
    .mem_wb_zero_o  (mem_wb_zero),
    .stall_cycles_o (stall_cycles)
  );

  function automatic vec_t v(logic r, logic [4:0] rs, logic [4:0] rt, logic urt,
                             logic [4:0] rd, logic mr, logic br, logic [31:0] tgt,
                             logic iq, logic ir, logic dq, logic dr,
                             logic [9:0] ctl, logic [31:0] rpc, logic [31:0] cnt);
    vec_t t;
    t.rst = r; t.rs = rs; t.rt = rt; t.use_rt = urt; t.rd = rd; t.mem_read = mr;
    t.br = br; t.tgt = tgt; t.i_req = iq; t.i_ready = ir; t.d_req = dq; t.d_ready = dr;
    t.ctl = ctl; t.rpc = rpc; t.cnt = cnt;
    return t;
  endfunction

  // Drive one cycle, check combinational controls mid-cycle, then registered state.
  task automatic apply(input vec_t t, input string name);
    logic [9:0] got;
    logic [CntW-1:0] exp_cnt;
    rst = t.rst; id_rs = t.rs; id_rt = t.rt; id_use_rt = t.use_rt; ex_rd = t.rd;
    ex_mem_read = t.mem_read; ex_br_taken = t.br; ex_br_target = t.tgt;
    i_req = t.i_req; i_ready = t.i_ready; d_req = t.d_req; d_ready = t.d_ready;
    @(negedge clk);
    got = {pc_we, pc_redirect, if_id_we, if_id_zero, id_ex_we, id_ex_zero,
           ex_mem_we, ex_mem_zero, mem_wb_we, mem_wb_zero};
    checks++;
    if (got !== t.ctl) begin
      errors++;
      $display("FAIL %s ctl: got=%b exp=%b", name, got, t.ctl);
    end
    @(posedge clk);
    #1;
    checks++;
    if (redirect_pc !== t.rpc) begin
      errors++;
      $display("FAIL %s redirect_pc: got=%h exp=%h", name, redirect_pc, t.rpc);
    end
    exp_cnt = t.cnt[CntW-1:0];
    checks++;
    if (stall_cycles !== exp_cnt) begin
      errors++;
      $display("FAIL %s stall_cycles: got=%0d exp=%0d", name, stall_cycles, exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          rst rs rt u rd mr br tgt      iq ir dq dr ctl      rpc      cnt
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h0,   0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h0,   0));
    tbl.push_back(v(0, 2, 0, 0, 2, 1, 0, 32'h0,   0, 0, 0, 0, LdUse,   32'h0,   1));
    tbl.push_back(v(0, 2, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h0,   1));
    tbl.push_back(v(0, 3, 5, 1, 5, 1, 0, 32'h0,   0, 0, 0, 0, LdUse,   32'h0,   2));
    tbl.push_back(v(0, 3, 5, 0, 5, 1, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h0,   2));
    tbl.push_back(v(0, 0, 0, 1, 0, 1, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h0,   2));
    tbl.push_back(v(0, 7, 0, 0, 7, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h0,   2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h40,  0, 0, 0, 0, Br,      32'h40,  2));
    tbl.push_back(v(0, 2, 0, 0, 2, 1, 1, 32'h100, 0, 0, 0, 0, Br,      32'h100, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h100, 2));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 0, DMiss,   32'h100, 3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 0, DMiss,   32'h100, 4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 0, DMiss,   32'h100, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 1, Br,      32'h200, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h200, 5));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 0, DMiss,   32'h200, 6));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 1, 1, IMiss,   32'h200, 7));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 0, IMiss,   32'h200, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 1, 0, 0, Norm,    32'h200, 8));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,    32'h200, 8));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // I-miss held 4 cycles with a taken branch in cycle 2: redirect waits for i_ready.
    apply(v(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, Norm,    32'h0,  0), "imiss_rst");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 0, IMiss,   32'h0,  1), "imiss_c1");
    apply(v(0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0, 0, BrPend,  32'h80, 2), "imiss_c2");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 0, IMiss,   32'h80, 3), "imiss_c3");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 0, IMiss,   32'h80, 4), "imiss_c4");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  1, 1, 0, 0, IRdyPnd, 32'h80, 4), "imiss_rdy");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, Norm,    32'h80, 4), "imiss_after");

    // Reset while waiting on the D-cache.
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, DMiss,   32'h80, 5), "dwait_c1");
    apply(v(1, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 1, 0, DMiss,   32'h0,  0), "dwait_rst");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, Norm,    32'h0,  0), "dwait_after");

    // Reset while waiting on the I-cache with a redirect pending: both must clear.
    apply(v(0, 0, 0, 0, 0, 0, 1, 32'h300, 1, 0, 0, 0, BrPend, 32'h300, 1), "iwait_br");
    apply(v(1, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, IMiss,  32'h0,   0), "iwait_rst");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 0, 0, 0, Norm,   32'h0,   0), "iwait_run");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 0, 0, 0, IMiss,  32'h0,   1), "iwait_miss");
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0,   1, 1, 0, 0, Norm,   32'h0,   1), "iwait_nopend");

    // Stall counter wraps at 2^CntW.
    apply(v(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, Norm, 32'h0, 0), "wrap_rst");
    for (int i = 1; i <= 20; i++)
      apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, DMiss, 32'h0, i),
            $sformatf("wrap_c%0d", i));
    apply(v(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, Norm, 32'h0, 20), "wrap_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
